// File: rtl/qft_n_qubit_seq_if.sv
// qft_n_qubit_seq_if: state-vector handshake bundle between a producer/consumer and qft_n_qubit_seq.
interface qft_n_qubit_seq_if #(
    parameter int NUM_QUBITS = 3,
    parameter int TOTAL_BITS = 8
);
    localparam int VW = TOTAL_BITS * 2 * (1 << NUM_QUBITS);
    logic          in_valid;
    logic          in_ready;
    logic          inverse;
    logic [VW-1:0] q_state_in;
    logic [VW-1:0] q_state_out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    modport master (output in_valid, inverse, q_state_in, out_ready,
                    input in_ready, q_state_out, out_valid, busy);
    modport slave (input in_valid, inverse, q_state_in, out_ready,
                   output in_ready, q_state_out, out_valid, busy);
endinterface

// File: rtl/qft_n_qubit_seq.sv
// qft_n_qubit_seq: sequential fixed-point N-qubit QFT; one Hadamard butterfly or one phase rotation per cycle.
module qft_n_qubit_seq #(
    parameter int NUM_QUBITS = 3,
    parameter int TOTAL_BITS = 8,
    parameter int FX_BITS    = 4
) (
    input logic clk,
    input logic rst_n,
    qft_n_qubit_seq_if.slave bus
);
    localparam int N  = NUM_QUBITS;
    localparam int M  = 1 << N;
    localparam int W  = TOTAL_BITS;
    localparam int XW = 2 * W + 6;
    localparam int CW = N - 1;
    localparam logic signed [XW-1:0] MAX_V = XW'((1 << (W - 1)) - 1);
    localparam logic signed [XW-1:0] MIN_V = -MAX_V - XW'(1);
    localparam logic signed [XW-1:0] K_H = XW'(11);
    // cos(2*pi*k/16) * 2^14, rescaled to FX_BITS with round-to-nearest
    localparam int COS14 [16] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
                                  -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};

    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
        return v > MAX_V ? W'(MAX_V) : v < MIN_V ? W'(MIN_V) : v[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] trig(input int k);
        return W'((COS14[4'(k)] + (1 << (13 - FX_BITS))) >>> (14 - FX_BITS));
    endfunction

    function automatic logic [N-1:0] rev(input logic [N-1:0] x);
        for (int i = 0; i < N; i++) rev[i] = x[N-1-i];
    endfunction

    typedef enum logic [1:0] {IDLE, HAD, PHASE, DONE} state_t;
    state_t state_q, state_d;
    logic signed [W-1:0] re_q [M];
    logic signed [W-1:0] re_d [M];
    logic signed [W-1:0] im_q [M];
    logic signed [W-1:0] im_d [M];
    logic [1:0] j_q, j_d;
    logic [CW-1:0] c_q, c_d;
    logic inv_q, inv_d;
    int b;
    logic [N-1:0] lo, hi, p_raw, p;
    logic signed [W-1:0] cr, ci;
    logic signed [XW-1:0] ar, ai, br, bi;
    logic signed [W-1:0] bf_lo_r, bf_lo_i, bf_hi_r, bf_hi_i, ph_r, ph_i;

    // pair counter c expands to lo by inserting a 0 at bit b; hi is lo with bit b set
    always_comb begin
        b = N - 1 - int'(j_q);
        lo = N'(((int'(c_q) >> b) << (b + 1)) | (int'(c_q) & ((1 << b) - 1)));
        hi = lo | N'(1 << b);
        p_raw = N'((int'(hi) & ((1 << b) - 1)) << j_q);
        p = inv_q ? -p_raw : p_raw;
        cr = trig(int'(p) << (4 - N));
        ci = trig((int'(p) << (4 - N)) + 12);
        ar = re_q[lo];
        ai = im_q[lo];
        br = re_q[hi];
        bi = im_q[hi];
        bf_lo_r = sat(((ar + br) * K_H) >>> FX_BITS);
        bf_lo_i = sat(((ai + bi) * K_H) >>> FX_BITS);
        bf_hi_r = sat(((ar - br) * K_H) >>> FX_BITS);
        bf_hi_i = sat(((ai - bi) * K_H) >>> FX_BITS);
        ph_r = sat((br * cr - bi * ci) >>> FX_BITS);
        ph_i = sat((br * ci + bi * cr) >>> FX_BITS);
    end

    always_comb begin
        state_d = state_q;
        re_d = re_q;
        im_d = im_q;
        j_d = j_q;
        c_d = c_q;
        inv_d = inv_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                for (int r = 0; r < M; r++) begin
                    re_d[r] = bus.q_state_in[(M-1-r)*2*W + W +: W];
                    im_d[r] = bus.q_state_in[(M-1-r)*2*W +: W];
                end
                inv_d = bus.inverse;
                j_d = '0;
                c_d = '0;
                state_d = HAD;
            end
            HAD: begin
                re_d[lo] = bf_lo_r;
                im_d[lo] = bf_lo_i;
                re_d[hi] = bf_hi_r;
                im_d[hi] = bf_hi_i;
                c_d = c_q + 1'b1;
                if (&c_q) state_d = (int'(j_q) == N - 1) ? DONE : PHASE;
            end
            PHASE: begin
                re_d[hi] = ph_r;
                im_d[hi] = ph_i;
                c_d = c_q + 1'b1;
                if (&c_q) begin
                    j_d = j_q + 1'b1;
                    state_d = HAD;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            re_q <= '{default: '0};
            im_q <= '{default: '0};
            j_q <= '0;
            c_q <= '0;
            inv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q <= re_d;
            im_q <= im_d;
            j_q <= j_d;
            c_q <= c_d;
            inv_q <= inv_d;
        end
    end

    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy = state_q == HAD || state_q == PHASE;

    always_comb begin
        for (int r = 0; r < M; r++)
            bus.q_state_out[(M-1-r)*2*W +: 2*W] = {re_q[rev(N'(r))], im_q[rev(N'(r))]};
    end
endmodule

// File: tb/tb_qft_n_qubit_seq.sv
// tb_qft_n_qubit_seq: random and directed transforms on N=2 and N=3 instances against a floating-point-phase reference model.
module tb_qft_n_qubit_seq;
    localparam int W = 8;
    localparam int FX = 4;
    localparam real PI = 3.14159265358979323846;
    typedef int vec_t [16];
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;

    qft_n_qubit_seq_if #(.NUM_QUBITS(2), .TOTAL_BITS(W)) b2 ();
    qft_n_qubit_seq_if #(.NUM_QUBITS(3), .TOTAL_BITS(W)) b3 ();
    qft_n_qubit_seq #(.NUM_QUBITS(2), .TOTAL_BITS(W), .FX_BITS(FX)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    qft_n_qubit_seq #(.NUM_QUBITS(3), .TOTAL_BITS(W), .FX_BITS(FX)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int n, input logic v, input logic inv, input logic [255:0] d);
        if (n == 2) begin
            b2.in_valid = v;
            b2.inverse = inv;
            b2.q_state_in = d[63:0];
        end else begin
            b3.in_valid = v;
            b3.inverse = inv;
            b3.q_state_in = d[127:0];
        end
    endtask

    task automatic set_ordy(input int n, input logic v);
        if (n == 2) b2.out_ready = v;
        else b3.out_ready = v;
    endtask

    function automatic logic [2:0] stat(input int n);
        return n == 2 ? {b2.in_ready, b2.out_valid, b2.busy} : {b3.in_ready, b3.out_valid, b3.busy};
    endfunction

    function automatic logic [255:0] dout(input int n);
        return n == 2 ? {192'd0, b2.q_state_out} : {128'd0, b3.q_state_out};
    endfunction

    function automatic int sat(input int v);
        return v > (1 << (W - 1)) - 1 ? (1 << (W - 1)) - 1 : v < -(1 << (W - 1)) ? -(1 << (W - 1)) : v;
    endfunction

    function automatic int rev(input int r, input int n);
        int x = 0;
        for (int t = 0; t < n; t++) if (((r >> t) & 1) == 1) x |= 1 << (n - 1 - t);
        return x;
    endfunction

    function automatic logic [255:0] pack(input int n, input vec_t re, input vec_t im);
        logic [255:0] v = '0;
        int m = 1 << n;
        for (int r = 0; r < m; r++) v[(m-1-r)*16 +: 16] = {8'(re[r]), 8'(im[r])};
        return v;
    endfunction

    // textbook QFT sweep: Hadamard on each qubit, controlled phases, then qubit-order reversal
    function automatic logic [255:0] model(input int n, input vec_t re_in, input vec_t im_in, input bit inv);
        int m, b, hi, p, sr, si, dr, di, cr, ci, xr, xi;
        real ang;
        vec_t re, im, ro, io;
        m = 1 << n;
        re = re_in;
        im = im_in;
        for (int q = 0; q < n; q++) begin
            b = n - 1 - q;
            for (int lo = 0; lo < m; lo++) begin
                if (((lo >> b) & 1) == 0) begin
                    hi = lo | (1 << b);
                    sr = re[lo] + re[hi];
                    dr = re[lo] - re[hi];
                    si = im[lo] + im[hi];
                    di = im[lo] - im[hi];
                    re[lo] = sat((sr * 11) >>> FX);
                    re[hi] = sat((dr * 11) >>> FX);
                    im[lo] = sat((si * 11) >>> FX);
                    im[hi] = sat((di * 11) >>> FX);
                end
            end
            if (q < n - 1) begin
                for (int i = 0; i < m; i++) begin
                    if (((i >> b) & 1) == 1) begin
                        p = ((i % (1 << b)) << q) % m;
                        if (inv) p = (m - p) % m;
                        ang = 2.0 * PI * p / m;
                        cr = $rtoi($floor($cos(ang) * (1 << FX) + 0.5));
                        ci = $rtoi($floor($sin(ang) * (1 << FX) + 0.5));
                        xr = sat((re[i] * cr - im[i] * ci) >>> FX);
                        xi = sat((re[i] * ci + im[i] * cr) >>> FX);
                        re[i] = xr;
                        im[i] = xi;
                    end
                end
            end
        end
        ro = '{default: 0};
        io = '{default: 0};
        for (int r = 0; r < m; r++) begin
            ro[r] = re[rev(r, n)];
            io[r] = im[rev(r, n)];
        end
        return pack(n, ro, io);
    endfunction

    task automatic rnd(output vec_t v);
        for (int i = 0; i < 16; i++) v[i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic run(input int n, input vec_t re, input vec_t im, input bit inv,
                       input logic [255:0] exp, input int stall, input string tag);
        int lat;
        vec_t jr, ji;
        chk({tag, "_rdy"}, stat(n), 3'b100);
        drive(n, 1'b1, inv, pack(n, re, im));
        @(posedge clk); #1;
        drive(n, 1'b0, 1'b0, '0);
        chk({tag, "_busy"}, stat(n), 3'b001);
        lat = 0;
        while (stat(n) != 3'b010 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, (2 * n - 1) * (1 << (n - 1)));
        for (int k = 0; k < stall; k++) begin
            rnd(jr);
            rnd(ji);
            drive(n, 1'b1, k[0], pack(n, jr, ji));
            @(posedge clk); #1;
            chk({tag, "_hold_st"}, stat(n), 3'b010);
            chk({tag, "_hold_dat"}, dout(n), exp);
        end
        drive(n, 1'b0, 1'b0, '0);
        chk({tag, "_data"}, dout(n), exp);
        set_ordy(n, 1'b1);
        @(posedge clk); #1;
        set_ordy(n, 1'b0);
        chk({tag, "_idle"}, stat(n), 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec_t z, e0, e1, big, full, re, im;
        bit inv, seen;
        int n;
        z = '{default: 0};
        e0 = z;
        e0[0] = 16;
        e1 = z;
        e1[1] = 16;
        big = z;
        big[0] = 127;
        full = '{default: 127};
        drive(2, 1'b0, 1'b0, '0);
        drive(3, 1'b0, 1'b0, '0);
        set_ordy(2, 1'b0);
        set_ordy(3, 1'b0);
        #2 rst_n = 1'b0;
        #10;
        chk("rst_st2", stat(2), 3'b100);
        chk("rst_st3", stat(3), 3'b100);
        chk("rst_dat2", dout(2), '0);
        chk("rst_dat3", dout(3), '0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run(2, e0, z, 1'b0, 256'(64'h0700_0700_0700_0700), 0, "basis00");
        run(2, e1, z, 1'b0, 256'(64'h0700_0007_F800_00F8), 0, "basis01");
        run(2, e1, z, 1'b1, 256'(64'h0700_00F8_F800_0007), 0, "basis01_inv");
        run(3, big, z, 1'b0, 256'(128'h2800_2800_2800_2800_2800_2800_2800_2800), 0, "n3_big");
        run(3, full, full, 1'b0, model(3, full, full, 1'b0), 0, "n3_sat");
        run(3, full, full, 1'b1, model(3, full, full, 1'b1), 0, "n3_sat_inv");

        rnd(re);
        rnd(im);
        run(3, re, im, 1'b1, model(3, re, im, 1'b1), 10, "stall");
        rnd(re);
        rnd(im);
        run(3, re, im, 1'b0, model(3, re, im, 1'b0), 0, "after_stall");

        drive(2, 1'b1, 1'b0, pack(2, e0, z));
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_phase_busy", stat(2), 3'b001);
        rst_n = 1'b0;
        #1;
        chk("abort_st", stat(2), 3'b100);
        chk("abort_dat", dout(2), '0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (stat(2)[1]) seen = 1'b1;
        end
        chk("abort_no_ovalid", seen, 1'b0);
        run(2, e0, z, 1'b0, 256'(64'h0700_0700_0700_0700), 0, "post_abort");

        for (int it = 0; it < 24; it++) begin
            n = 2 + (it % 2);
            rnd(re);
            rnd(im);
            inv = 1'($urandom_range(1));
            run(n, re, im, inv, model(n, re, im, inv), 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/qft_n_qubit_seq.md
QFT_N_QUBIT_SEQ -- requirements
Module: qft_n_qubit_seq

Interface
REQ-001 SHALL have parameter NUM_QUBITS, default 3: qubit count N; legal range 2..4.
REQ-002 SHALL have parameter TOTAL_BITS, default 8: signed fixed-point word width per real or imaginary part.
REQ-003 SHALL have parameter FX_BITS, default 4: fractional bits (S_3.4 at defaults).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have `clk`, input, 1 bit: the clock; all state changes on its rising edge.
REQ-006 SHALL have `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have `in_valid`, input, 1 bit: input state vector present.
REQ-008 SHALL have `in_ready`, output, 1 bit: block can accept a state vector.
REQ-009 SHALL have `inverse`, input, 1 bit: sampled with the input; 1 = inverse QFT.
REQ-010 SHALL have `q_state_in`, input, TOTAL_BITS*2*2^N bits: amplitude index 0 in the MSBs, index 2^N-1 in the LSBs; each amplitude is {real, imag}.
REQ-011 SHALL have `q_state_out`, output, TOTAL_BITS*2*2^N bits: result, same packing.
REQ-012 SHALL have `out_valid`, output, 1 bit: result held on q_state_out.
REQ-013 SHALL have `out_ready`, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have `busy`, output, 1 bit: high in HAD or PHASE.

Function
REQ-015 SHALL implement FSM states IDLE, HAD, PHASE and DONE; in_ready = (state==IDLE).
REQ-016 When in_valid && in_ready: SHALL load internal amplitude storage from q_state_in, latch inverse, set j=0, pair counter c=0, and go to HAD.
REQ-017 SHALL map qubit j to index bit position b = N-1-j (qubit 0 = MSB).
REQ-018 HAD SHALL process one butterfly per cycle over index pairs (lo, hi) that differ only in bit b, in ascending lo order; 2^(N-1) cycles per qubit.
REQ-019 Each butterfly SHALL compute new_lo = sat((a_lo+a_hi)*11 >>> FX_BITS) and new_hi = sat((a_lo-a_hi)*11 >>> FX_BITS), per real/imag part.
REQ-020 Intermediate sums SHALL be TOTAL_BITS+1 wide; the shift SHALL be arithmetic (floor); sat SHALL clamp to [-2^(TOTAL_BITS-1), 2^(TOTAL_BITS-1)-1].
REQ-021 After HAD for j < N-1, SHALL enter PHASE; after HAD for j = N-1, SHALL enter DONE.
REQ-022 PHASE SHALL visit, one per cycle in ascending order, each of the 2^(N-1) indices i with bit b set, multiplying a_i by e^(i*2*pi*p/2^N); p = ((i mod 2^b) << j) mod 2^N.
REQ-023 When inverse is latched, PHASE SHALL use p' = (2^N - p) mod 2^N.
REQ-024 Phase factors SHALL be an internal constant table: cos/sin times 2^FX_BITS, rounded to nearest; 1.0 = 16 at defaults.
REQ-025 Complex multiply SHALL compute re = sat((ar*cr - ai*ci) >>> FX_BITS) and im = sat((ar*ci + ai*cr) >>> FX_BITS); p=0 leaves a_i unchanged.
REQ-026 After PHASE, SHALL set j=j+1 and return to HAD.
REQ-027 Compute latency SHALL be (2N-1)*2^(N-1) cycles from the accepting edge to out_valid=1: 6, 20 and 56 for N = 2, 3 and 4.
REQ-028 In DONE, out_valid SHALL be 1 and q_state_out SHALL hold amplitude r = stored amplitude bitreverse_N(r) (the qubit swap), stable until accepted.
REQ-029 When out_valid && out_ready, SHALL go to IDLE; in_ready rises the next cycle, so there is no same-cycle reload.
REQ-030 In_valid SHALL be ignored while not in IDLE; the stored vector and latched inverse SHALL NOT change until IDLE.
REQ-031 Outside DONE, out_valid SHALL be 0; q_state_out SHALL continuously reflect the bit-reversed storage and SHALL only be sampled when out_valid is high.

Reset
REQ-032 When rst_n is low, SHALL go to IDLE at once and clear storage, j, c, latched inverse, out_valid and busy to 0; in_ready = 1.
REQ-033 Reset asserted mid-HAD, mid-PHASE or mid-DONE SHALL abort the transform; the result SHALL be discarded and no out_valid pulse SHALL follow.

Verification
REQ-034 N=2, input |00> = (16,0), all other amplitudes 0 -> after 6 cycles out_valid=1 and all four outputs = (7,0).
REQ-035 N=2, input |01> = (16,0) -> outputs [(7,0), (0,7), (-8,0), (0,-8)].
REQ-036 N=2, input |01>, inverse=1 -> outputs [(7,0), (0,-8), (-8,0), (0,7)].
REQ-037 N=3, input |000> = (127,0) -> out_valid after exactly 20 cycles; all outputs equal and no overflow wrap (saturation path checked with (127,127) input).
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid and data stable, in_ready=0 and a new in_valid ignored; after release, the next accept works.
REQ-039 rst_n pulsed low in PHASE -> in IDLE immediately with outputs 0 and no out_valid; a fresh transform afterwards matches REQ-034.
